// File: rtl/instruction_control_fsm_pkg.sv
// Shared ISA definitions for the instruction control FSM and the PC-side decode:
// opcode/ext fields, condition codes, flag bit positions, FSM encodings, cond_met().
package instruction_control_fsm_pkg;

    localparam logic [3:0] OP_ALU   = 4'b0000;
    localparam logic [3:0] OP_ANDI  = 4'b0001;
    localparam logic [3:0] OP_ORI   = 4'b0010;
    localparam logic [3:0] OP_XORI  = 4'b0011;
    localparam logic [3:0] OP_MEM   = 4'b0100;
    localparam logic [3:0] OP_BCOND = 4'b1100;
    localparam logic [3:0] OP_LUI   = 4'b1111;

    localparam logic [3:0] EXT_LOAD  = 4'b0000;
    localparam logic [3:0] EXT_STOR  = 4'b0100;
    localparam logic [3:0] EXT_JAL   = 4'b1000;
    localparam logic [3:0] EXT_JCOND = 4'b1100;

    localparam logic [3:0] COND_EQ  = 4'd0;
    localparam logic [3:0] COND_NE  = 4'd1;
    localparam logic [3:0] COND_CS  = 4'd2;
    localparam logic [3:0] COND_CC  = 4'd3;
    localparam logic [3:0] COND_HI  = 4'd4;
    localparam logic [3:0] COND_LS  = 4'd5;
    localparam logic [3:0] COND_GT  = 4'd6;
    localparam logic [3:0] COND_LE  = 4'd7;
    localparam logic [3:0] COND_FS  = 4'd8;
    localparam logic [3:0] COND_FC  = 4'd9;
    localparam logic [3:0] COND_LO  = 4'd10;
    localparam logic [3:0] COND_HS  = 4'd11;
    localparam logic [3:0] COND_LT  = 4'd12;
    localparam logic [3:0] COND_GE  = 4'd13;
    localparam logic [3:0] COND_UC  = 4'd14;
    localparam logic [3:0] COND_JAL = 4'd15;

    localparam int unsigned FLAG_C = 0;
    localparam int unsigned FLAG_L = 1;
    localparam int unsigned FLAG_F = 2;
    localparam int unsigned FLAG_Z = 3;
    localparam int unsigned FLAG_N = 4;

    localparam logic [2:0] ST_FETCH  = 3'd0;
    localparam logic [2:0] ST_DECODE = 3'd1;
    localparam logic [2:0] ST_EXEC   = 3'd2;
    localparam logic [2:0] ST_MEM_WB = 3'd3;
    localparam logic [2:0] ST_HALT   = 3'd4;

    localparam logic [1:0] WB_SEL_ALU  = 2'd0;
    localparam logic [1:0] WB_SEL_MEM  = 2'd1;
    localparam logic [1:0] WB_SEL_LINK = 2'd2;

    function automatic logic cond_met(input logic [3:0] cond, input logic [4:0] flags);
        logic c, l, f, z, n;
        c = flags[FLAG_C];
        l = flags[FLAG_L];
        f = flags[FLAG_F];
        z = flags[FLAG_Z];
        n = flags[FLAG_N];
        case (cond)
            COND_EQ: cond_met = z;
            COND_NE: cond_met = !z;
            COND_CS: cond_met = c;
            COND_CC: cond_met = !c;
            COND_HI: cond_met = l;
            COND_LS: cond_met = !l;
            COND_GT: cond_met = n;
            COND_LE: cond_met = !n;
            COND_FS: cond_met = f;
            COND_FC: cond_met = !f;
            COND_LO: cond_met = !l && !z;
            COND_HS: cond_met = l || z;
            COND_LT: cond_met = !n && !z;
            COND_GE: cond_met = n || z;
            COND_UC: cond_met = 1'b1;
            default: cond_met = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/instruction_control_fsm_if.sv
// Memory/datapath/PC-facing bundle of the instruction control FSM.
interface instruction_control_fsm_if #(
    parameter int unsigned WIDTH = 16
);
    logic [WIDTH-1:0] instr_in;
    logic [4:0]       flag_register;
    logic [WIDTH-1:0] pc_address;

    logic             mem_addr_sel;
    logic             mem_write;
    logic             reg_write;
    logic [1:0]       reg_write_sel;
    logic [3:0]       r_dest;
    logic [3:0]       r_src;
    logic [7:0]       alu_op;
    logic             alu_imm_sel;
    logic [WIDTH-1:0] immediate;
    logic [WIDTH-1:0] link_value;
    logic             flag_write;
    logic [3:0]       flag_op;
    logic             pc_add;
    logic             pc_jump;
    logic             pc_branch;
    logic             halted;

    modport master (
        input  instr_in, flag_register, pc_address,
        output mem_addr_sel, mem_write, reg_write, reg_write_sel, r_dest, r_src,
               alu_op, alu_imm_sel, immediate, link_value, flag_write, flag_op,
               pc_add, pc_jump, pc_branch, halted
    );

    modport slave (
        output instr_in, flag_register, pc_address,
        input  mem_addr_sel, mem_write, reg_write, reg_write_sel, r_dest, r_src,
               alu_op, alu_imm_sel, immediate, link_value, flag_write, flag_op,
               pc_add, pc_jump, pc_branch, halted
    );
endinterface

// File: rtl/instruction_control_fsm_branch_cond_eval.sv
// Combinational branch condition evaluator wrapping the shared cond_met().
module branch_cond_eval
    import instruction_control_fsm_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [4:0] flags,
    output logic       met
);
    assign met = cond_met(cond, flags);
endmodule

// File: rtl/instruction_control_fsm.sv
// Multi-cycle fetch/decode/execute control FSM driving datapath strobes and the
// PC command interface; each instruction retires with exactly one PC strobe.
module instruction_control_fsm
    import instruction_control_fsm_pkg::*;
#(
    parameter int unsigned      WIDTH     = 16,
    parameter logic [WIDTH-1:0] HALT_WORD = 16'hFFFF
) (
    input logic                       clk,
    input logic                       reset,
    instruction_control_fsm_if.master bus
);

    logic [2:0]       state;
    logic [2:0]       state_next;
    logic [WIDTH-1:0] ir;

    logic [3:0] op;
    logic [3:0] ext;
    logic       is_alu_reg, is_logic_imm, is_lui, is_mem, is_bcond;
    logic       is_load, is_stor, is_jcond, is_jal;
    logic       branch_taken;

    logic [WIDTH-1:0] imm_zx, imm_sx, imm_hi;

    logic       mem_addr_sel, mem_write, reg_write, alu_imm_sel, flag_write;
    logic [1:0] reg_write_sel;
    logic       pc_add, pc_jump, pc_branch, halted;

    assign op  = ir[15:12];
    assign ext = ir[7:4];

    assign is_alu_reg   = (op == OP_ALU);
    assign is_logic_imm = (op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI);
    assign is_lui       = (op == OP_LUI);
    assign is_mem       = (op == OP_MEM);
    assign is_bcond     = (op == OP_BCOND);
    assign is_load      = is_mem && (ext == EXT_LOAD);
    assign is_stor      = is_mem && (ext == EXT_STOR);
    assign is_jcond     = is_mem && (ext == EXT_JCOND);
    assign is_jal       = is_mem && (ext == EXT_JAL);

    branch_cond_eval u_cond (
        .cond  (ir[11:8]),
        .flags (bus.flag_register),
        .met   (branch_taken)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_FETCH;
            ir    <= '0;
        end else begin
            state <= state_next;
            if (state == ST_DECODE) begin
                ir <= bus.instr_in;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_FETCH:  state_next = ST_DECODE;
            ST_DECODE: state_next = (bus.instr_in == HALT_WORD) ? ST_HALT : ST_EXEC;
            ST_EXEC:   state_next = is_load ? ST_MEM_WB : ST_FETCH;
            ST_MEM_WB: state_next = ST_FETCH;
            ST_HALT:   state_next = ST_HALT;
            default:   state_next = ST_FETCH;
        endcase
    end

    // Reset gates every strobe combinationally so an aborted instruction never retires.
    always_comb begin
        mem_addr_sel  = 1'b0;
        mem_write     = 1'b0;
        reg_write     = 1'b0;
        reg_write_sel = WB_SEL_ALU;
        alu_imm_sel   = 1'b0;
        flag_write    = 1'b0;
        pc_add        = 1'b0;
        pc_jump       = 1'b0;
        pc_branch     = 1'b0;
        halted        = 1'b0;
        if (!reset) begin
            case (state)
                ST_EXEC: begin
                    if (is_alu_reg) begin
                        reg_write  = 1'b1;
                        flag_write = 1'b1;
                        pc_add     = 1'b1;
                    end else if (is_lui) begin
                        alu_imm_sel = 1'b1;
                        reg_write   = 1'b1;
                        pc_add      = 1'b1;
                    end else if (is_bcond) begin
                        pc_branch = branch_taken;
                        pc_add    = !branch_taken;
                    end else if (is_load) begin
                        mem_addr_sel = 1'b1;
                    end else if (is_stor) begin
                        mem_addr_sel = 1'b1;
                        mem_write    = 1'b1;
                        pc_add       = 1'b1;
                    end else if (is_jcond) begin
                        pc_jump = 1'b1;
                    end else if (is_jal) begin
                        reg_write     = 1'b1;
                        reg_write_sel = WB_SEL_LINK;
                        pc_jump       = 1'b1;
                    end else if (is_mem) begin
                        pc_add = 1'b1;
                    end else begin
                        alu_imm_sel = 1'b1;
                        reg_write   = 1'b1;
                        flag_write  = 1'b1;
                        pc_add      = 1'b1;
                    end
                end
                ST_MEM_WB: begin
                    reg_write     = 1'b1;
                    reg_write_sel = WB_SEL_MEM;
                    pc_add        = 1'b1;
                end
                ST_HALT: halted = 1'b1;
                default: ;
            endcase
        end
    end

    assign imm_zx = WIDTH'(ir[7:0]);
    assign imm_sx = WIDTH'($signed(ir[7:0]));
    assign imm_hi = WIDTH'({ir[7:0], 8'h00});

    assign bus.immediate  = is_lui ? imm_hi : (is_logic_imm ? imm_zx : imm_sx);
    assign bus.flag_op    = is_jal ? COND_JAL : ((is_bcond || is_jcond) ? ir[11:8] : COND_JAL);
    assign bus.r_dest     = ir[11:8];
    assign bus.r_src      = ir[3:0];
    assign bus.alu_op     = {ir[15:12], ir[7:4]};
    assign bus.link_value = bus.pc_address + WIDTH'(1);

    assign bus.mem_addr_sel  = mem_addr_sel;
    assign bus.mem_write     = mem_write;
    assign bus.reg_write     = reg_write;
    assign bus.reg_write_sel = reg_write_sel;
    assign bus.alu_imm_sel   = alu_imm_sel;
    assign bus.flag_write    = flag_write;
    assign bus.pc_add        = pc_add;
    assign bus.pc_jump       = pc_jump;
    assign bus.pc_branch     = pc_branch;
    assign bus.halted        = halted;

endmodule
